edf_arbiter: RTL and testbench
==============================

// Module: edf_arbiter
// PURPOSE
//  Earliest-Deadline-First arbiter for the MemorEDF request path. Tracks a per-requester
//  countdown deadline, picks the pending requester with the smallest remaining deadline
//  and drives the Selector index that muxes that requester onto the shared memory port.
//  Holds the grant stable until downstream accepts, then pops the served requester.
// PARAMETERS
//  INPUTS        4   number of requesters (queues); index width = $clog2(INPUTS)
//  DEADLINE_SIZE 16  width of period inputs and deadline counters
// PORTS
//  clock        in   1                       single clock, all state on rising edge
//  reset        in   1                       asynchronous, active-low reset
//  valid        in   INPUTS                  valid[i]=1: requester i has a pending head request
//  period       in   [INPUTS][DEADLINE_SIZE] relative deadline of requester i, in cycles
//  ready        in   1                       downstream memory port accepts this cycle
//  index        out  $clog2(INPUTS)          granted requester; drives Selector index
//  index_valid  out  1                       index is a live grant
//  pop          out  INPUTS                  one-hot, 1 cycle: head of requester i consumed
//  miss         out  INPUTS                  sticky: requester i deadline reached 0 while pending
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (reset=0): state=IDLE, index=0, index_valid=0, pop=0, miss=0, all d[i]=all-ones,
//   valid_q=0. Reset mid-grant drops the grant immediately; no pop is issued.
//  Deadline counter d[i], per cycle, priority order:
//   1. pop[i]=1 or (valid[i]=1 and valid_q[i]=0): d[i] <= period[i]; miss[i] <= 0.
//   2. else valid[i]=1 and d[i]!=0: d[i] <= d[i]-1.
//   3. else valid[i]=1 and d[i]==0: hold 0, miss[i] <= 1 (sticky until next reload).
//   4. else (valid[i]=0): hold.
//   valid_q is valid registered. Counters saturate at 0, never wrap. period=0 => always urgent.
//  Selection (combinational): among valid[i]=1, minimum d[i]; ties -> lowest index.
//  FSM:
//   IDLE : if |valid: index<=winner, index_valid<=1, ->GRANT. Else stay, index_valid=0.
//   GRANT: index held stable (no preemption, even if a smaller deadline appears).
//          ready=1 and valid[index]=1: pop[index]=1 this cycle (comb: state==GRANT & ready),
//            index_valid<=0, ->IDLE.
//          valid[index]=0 (requester withdrew): no pop, index_valid<=0, ->IDLE.
//          else stay.
//  Latency: valid rise -> index_valid 1 cycle; ready in GRANT -> pop same cycle; next grant
//   earliest 1 cycle after pop (one IDLE cycle per transfer; max throughput 1 per 2 cycles).
//  Simultaneous: pop[i] with valid[i] rising edge -> single reload. Popped requester still
//   valid next cycle is re-armed with period[i] (treated as new head via rule 1 from pop).
//  period[i] sampled only at reload; changes mid-countdown take effect at next reload.
//  ready outside GRANT is ignored. index retains last value while index_valid=0.
// TESTING
//  1. Reset: assert reset=0 mid-GRANT -> index_valid=0, pop=0, miss=0 same cycle, d=all-ones.
//  2. Single req: period[2]=5, valid=4'b0100, ready=1 -> index=2, index_valid=1 after 1 cycle,
//     pop=4'b0100 next cycle, then IDLE.
//  3. EDF order: period={10,3,7,20}, valid=4'b1111 at t0, ready=1 -> grant order 1,2,0,3
//     (each re-armed after pop; check with valid dropped after its pop).
//  4. Tie: period={4,4,4,4}, all valid same cycle -> grant index 0 first.
//  5. Hold/no-preempt: grant 0 (period 8), ready=0 for 10 cycles, raise valid[3] period 0 ->
//     index stays 0; miss[0]=1 once d[0] hits 0; after ready, pop[0], next grant 3, miss[0]
//     clears on reload.
//  6. Withdraw: grant 1, drop valid[1] before ready -> no pop, index_valid=0, ->IDLE.

Source files
------------

// File: rtl/edf_arbiter.sv
// Earliest-Deadline-First arbiter: per-requester saturating countdown deadlines, picks the
// pending requester with the smallest remaining deadline and holds the grant until accepted.
module edf_arbiter #(
   parameter int INPUTS        = 4,
   parameter int DEADLINE_SIZE = 16
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [INPUTS-1:0]                      valid,
   input  logic [INPUTS-1:0][DEADLINE_SIZE-1:0]   period,
   input  logic                                   ready,
   output logic [$clog2(INPUTS)-1:0]              index,
   output logic                                   index_valid,
   output logic [INPUTS-1:0]                      pop,
   output logic [INPUTS-1:0]                      miss
);

   localparam int IW = $clog2(INPUTS);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                                r_state;
   state_t                                w_state_nxt;
   logic [IW-1:0]                         r_index;
   logic [IW-1:0]                         w_index_nxt;
   logic                                  r_index_valid;
   logic                                  w_index_valid_nxt;
   logic [INPUTS-1:0][DEADLINE_SIZE-1:0]  r_d;
   logic [INPUTS-1:0]                     r_valid_q;
   logic [INPUTS-1:0]                     r_miss;
   logic [INPUTS-1:0]                     w_pop;
   logic [IW-1:0]                         w_win;
   logic [DEADLINE_SIZE-1:0]              w_best_d;
   logic                                  w_found;

   // Minimum remaining deadline among pending requesters; strict compare keeps lowest index on ties.
   always_comb begin
      w_win    = {IW{1'b0}};
      w_best_d = {DEADLINE_SIZE{1'b1}};
      w_found  = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
         if (valid[i] && (!w_found || (r_d[i] < w_best_d))) begin
            w_found  = 1'b1;
            w_best_d = r_d[i];
            w_win    = IW'(i);
         end else begin
            w_found  = w_found;
         end
      end
   end

   // Head consumed only while the granted requester is still pending and downstream accepts.
   always_comb begin
      w_pop = {INPUTS{1'b0}};
      if ((r_state == GRANT) && ready && valid[r_index]) begin
         w_pop = {{(INPUTS-1){1'b0}}, 1'b1} << r_index;
      end else begin
         w_pop = {INPUTS{1'b0}};
      end
   end

   // Next-state and grant bookkeeping.
   always_comb begin
      w_state_nxt       = r_state;
      w_index_nxt       = r_index;
      w_index_valid_nxt = r_index_valid;
      case (r_state)
         IDLE: begin
            if (|valid) begin
               w_index_nxt       = w_win;
               w_index_valid_nxt = 1'b1;
               w_state_nxt       = GRANT;
            end else begin
               w_index_valid_nxt = 1'b0;
            end
         end
         GRANT: begin
            if (!valid[r_index] || ready) begin
               w_index_valid_nxt = 1'b0;
               w_state_nxt       = IDLE;
            end else begin
               w_state_nxt       = GRANT;
            end
         end
         default: begin
            w_index_valid_nxt = 1'b0;
            w_state_nxt       = IDLE;
         end
      endcase
   end

   // FSM state and grant registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_index       <= {IW{1'b0}};
         r_index_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_index       <= w_index_nxt;
         r_index_valid <= w_index_valid_nxt;
      end
   end

   // Per-requester deadline countdown: reload on pop or new head, saturate at zero, flag misses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_d       <= {INPUTS{{DEADLINE_SIZE{1'b1}}}};
         r_valid_q <= {INPUTS{1'b0}};
         r_miss    <= {INPUTS{1'b0}};
      end else begin
         r_valid_q <= valid;
         for (int i = 0; i < INPUTS; i++) begin
            if (w_pop[i] || (valid[i] && !r_valid_q[i])) begin
               r_d[i]    <= period[i];
               r_miss[i] <= 1'b0;
            end else if (valid[i] && (r_d[i] != {DEADLINE_SIZE{1'b0}})) begin
               r_d[i]    <= r_d[i] - {{(DEADLINE_SIZE-1){1'b0}}, 1'b1};
            end else if (valid[i]) begin
               r_miss[i] <= 1'b1;
            end else begin
               r_d[i]    <= r_d[i];
            end
         end
      end
   end

   assign index       = r_index;
   assign index_valid = r_index_valid;
   assign pop         = w_pop;
   assign miss        = r_miss;

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed self-checking bench for edf_arbiter: reset, single request, EDF ordering,
// ties, no-preemption with deadline miss, and requester withdrawal.
module tb_edf_arbiter;

   logic              clock;
   logic              reset;
   logic [3:0]        valid;
   logic [3:0][15:0]  period;
   logic              ready;
   logic [1:0]        index;
   logic              index_valid;
   logic [3:0]        pop;
   logic [3:0]        miss;

   int n_cmp  = 0;
   int n_fail = 0;

   edf_arbiter #(.INPUTS(4), .DEADLINE_SIZE(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .valid       (valid),
      .period      (period),
      .ready       (ready),
      .index       (index),
      .index_valid (index_valid),
      .pop         (pop),
      .miss        (miss)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset  = 1'b0;
      valid  = 4'b0000;
      period = '0;
      ready  = 1'b0;
      #2;
      chk("rst_iv",   32'(index_valid), 32'd0);
      chk("rst_idx",  32'(index),       32'd0);
      chk("rst_pop",  32'(pop),         32'd0);
      chk("rst_miss", 32'(miss),        32'd0);
      tick();
      reset = 1'b1;
      tick();

      // Single request
      period[2] = 16'd5;
      valid     = 4'b0100;
      ready     = 1'b1;
      #1;
      chk("t2_idle_iv", 32'(index_valid), 32'd0);
      tick();
      chk("t2_idx",  32'(index),       32'd2);
      chk("t2_iv",   32'(index_valid), 32'd1);
      chk("t2_pop",  32'(pop),         32'b0100);
      tick();
      valid = 4'b0000;
      #1;
      chk("t2_done_iv",  32'(index_valid), 32'd0);
      chk("t2_done_pop", 32'(pop),         32'd0);
      chk("t2_done_idx", 32'(index),       32'd2);

      // EDF order: arm deadlines, withdraw, then raise all together
      period[0] = 16'd10;
      period[1] = 16'd3;
      period[2] = 16'd7;
      period[3] = 16'd20;
      ready     = 1'b0;
      valid     = 4'b1111;
      tick();
      chk("t3_arm_iv", 32'(index_valid), 32'd1);
      valid = 4'b0000;
      tick();
      chk("t3_wd_iv",  32'(index_valid), 32'd0);
      chk("t3_wd_pop", 32'(pop),         32'd0);
      valid = 4'b1111;
      ready = 1'b1;
      tick();
      chk("t3_g1_idx", 32'(index), 32'd1);
      chk("t3_g1_pop", 32'(pop),   32'b0010);
      tick();
      valid = 4'b1101;
      #1;
      chk("t3_gap_iv", 32'(index_valid), 32'd0);
      tick();
      chk("t3_g2_idx", 32'(index), 32'd2);
      chk("t3_g2_pop", 32'(pop),   32'b0100);
      tick();
      valid = 4'b1001;
      tick();
      chk("t3_g3_idx", 32'(index), 32'd0);
      chk("t3_g3_pop", 32'(pop),   32'b0001);
      tick();
      valid = 4'b1000;
      tick();
      chk("t3_g4_idx", 32'(index), 32'd3);
      chk("t3_g4_pop", 32'(pop),   32'b1000);
      chk("t3_miss",   32'(miss),  32'd0);
      tick();
      valid = 4'b0000;
      ready = 1'b0;
      tick();

      // Hold without preemption, deadline miss on both requesters
      period[0] = 16'd8;
      period[3] = 16'd0;
      valid     = 4'b0001;
      tick();
      chk("t5_idx", 32'(index),       32'd0);
      chk("t5_iv",  32'(index_valid), 32'd1);
      chk("t5_pop", 32'(pop),         32'd0);
      tick();
      tick();
      valid = 4'b1001;
      for (int k = 4; k <= 8; k++) tick();
      tick();
      chk("t5_miss9",  32'(miss),  32'b1000);
      tick();
      chk("t5_miss10", 32'(miss),  32'b1001);
      chk("t5_hold",   32'(index), 32'd0);
      ready = 1'b1;
      #1;
      chk("t5_pop0", 32'(pop), 32'b0001);
      tick();
      valid = 4'b1000;
      #1;
      chk("t5_reload_miss", 32'(miss), 32'b1000);
      tick();
      chk("t5_g3_idx", 32'(index), 32'd3);
      chk("t5_g3_pop", 32'(pop),   32'b1000);

      // Reset in the middle of a grant
      reset = 1'b0;
      #1;
      chk("t1_iv",   32'(index_valid), 32'd0);
      chk("t1_pop",  32'(pop),         32'd0);
      chk("t1_miss", 32'(miss),        32'd0);
      chk("t1_idx",  32'(index),       32'd0);
      reset = 1'b1;
      valid = 4'b0000;
      ready = 1'b0;
      tick();

      // Tie on fresh reset deadlines
      period = {16'd4, 16'd4, 16'd4, 16'd4};
      valid  = 4'b1111;
      tick();
      chk("t4_idx", 32'(index),       32'd0);
      chk("t4_iv",  32'(index_valid), 32'd1);
      valid = 4'b0000;
      tick();
      chk("t4_end_iv", 32'(index_valid), 32'd0);

      // Withdraw before ready
      period[1] = 16'd5;
      valid     = 4'b0010;
      tick();
      chk("t6_idx", 32'(index),       32'd1);
      chk("t6_iv",  32'(index_valid), 32'd1);
      valid = 4'b0000;
      ready = 1'b1;
      #1;
      chk("t6_pop", 32'(pop), 32'd0);
      tick();
      chk("t6_iv0",  32'(index_valid), 32'd0);
      chk("t6_pop0", 32'(pop),         32'd0);
      tick();
      chk("t6_idle_iv", 32'(index_valid), 32'd0);
      chk("t6_miss",    32'(miss),        32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
